// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Instruction memory for the single-cycle fetch path, with a byte-serial
//   program loader. Fetch reads are combinational. A host streams a program
//   in little-endian bytes while `busy` holds the CPU in a stall.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   NOP_WORD     word returned while loading or when out of range
//
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   rd_addr        fetch byte address (PC); [1:0] ignored
//   rd_data        instruction word, combinational from rd_addr
//   rd_oor         word index >= DEPTH_WORDS (independent of busy)
//   load_start     pulse: begin a load session (ignored unless idle)
//   load_valid     load_byte is valid
//   load_byte      program byte
//   load_last      qualifies the final byte of the session
//   load_ready     loader accepts a byte this cycle
//   busy           loader active; CPU must stall
//   load_done      one-cycle pulse at session end
//   words_loaded   words written in the current or last session
module instr_mem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [31:0]                    rd_addr,
  output logic [31:0]                    rd_data,
  output logic                           rd_oor,
  input  logic                           load_start,
  input  logic                           load_valid,
  input  logic [7:0]                     load_byte,
  input  logic                           load_last,
  output logic                           load_ready,
  output logic                           busy,
  output logic                           load_done,
  output logic [$clog2(DEPTH_WORDS):0]   words_loaded
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [AW:0] r_wptr;
  logic [1:0]  r_lane;
  logic [31:0] r_asm;

  // Not reset; the declaration value gives NOP_WORD everywhere at power-up.
  logic [31:0] r_mem [DEPTH_WORDS] = '{default: NOP_WORD};

  logic        w_full;
  logic        w_accept;
  logic        w_write;
  logic [31:0] w_lane_word;
  logic [31:0] w_word;
  logic [AW:0] w_wptr_inc;
  logic [AW-1:0] w_rd_idx;
  logic        w_unused_addr;

  // Datapath decode
  always_comb begin
    w_full      = (r_wptr == FULL);
    w_accept    = (r_state == LOAD) && !w_full && load_valid;
    w_write     = w_accept && ((r_lane == 2'd3) || load_last);
    w_wptr_inc  = r_wptr + {{AW{1'b0}}, 1'b1};
    w_lane_word = '0;
    case (r_lane)
      2'd0:    w_lane_word = {24'h0, load_byte};
      2'd1:    w_lane_word = {16'h0, load_byte, 8'h0};
      2'd2:    w_lane_word = {8'h0, load_byte, 16'h0};
      default: w_lane_word = {load_byte, 24'h0};
    endcase
    // r_asm is cleared after every write, so upper lanes read as zero when a
    // short final word is flushed by load_last.
    w_word = r_asm | w_lane_word;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    load_ready   = 1'b0;
    load_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_start) w_state_next = LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        load_ready = !w_full;
        if ((w_accept && load_last) || (w_write && (w_wptr_inc == FULL)))
          w_state_next = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        load_done    = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_lane <= '0;
      r_asm  <= '0;
    end else if ((r_state == IDLE) && load_start) begin
      r_wptr <= '0;
      r_lane <= '0;
      r_asm  <= '0;
    end else if (w_accept) begin
      r_lane <= r_lane + 2'd1;
      if (w_write) begin
        r_asm  <= '0;
        r_wptr <= w_wptr_inc;
      end else begin
        r_asm  <= w_word;
      end
    end
  end

  // Gated by reset_n so a reset landing on a lane-3 byte does not commit it.
  always_ff @(posedge clk) begin
    if (reset_n && w_write) r_mem[r_wptr[AW-1:0]] <= w_word;
  end

  assign words_loaded  = r_wptr;

  // Read path: DEPTH_WORDS is a power of two, so any set bit above the index
  // field means the word is out of range.
  assign w_rd_idx      = rd_addr[AW+1:2];
  assign w_unused_addr = ^rd_addr[1:0];
  assign rd_oor        = |rd_addr[31:AW+2];
  assign rd_data       = (busy || rd_oor) ? NOP_WORD : r_mem[w_rd_idx];

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Instruction memory responder for the single-cycle fetch path, with a byte-serial program loader. It answers the fetch stage's word address with a combinational instruction word, and lets a host (UART bridge or testbench) stream a program in byte-by-byte while holding the CPU through the `busy` flag. The fetch stage feeds `busy` into its `hazard` input.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: number of 32-bit instruction words; a power of two, at least 4.
- `NOP_WORD`, default 32'h0000_0013: word returned while loading or when out of range (`addi x0,x0,0`).

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: synchronous, active-low reset.
- `rd_addr` in 32: fetch byte address (the fetch stage's PC).
- `rd_data` out 32: instruction word, combinational from `rd_addr`.
- `rd_oor` out 1: combinational; high when the word index is at or above `DEPTH_WORDS`.
- `load_start` in 1: pulse; begins a load session.
- `load_valid` in 1: `load_byte` is valid.
- `load_byte` in 8: program byte, little-endian stream.
- `load_last` in 1: qualifies the final byte of the session.
- `load_ready` out 1: loader accepts a byte this cycle.
- `busy` out 1: loader active; CPU must stall.
- `load_done` out 1: one-cycle pulse at session end.
- `words_loaded` out `$clog2(DEPTH_WORDS)+1`: words written in the current or last session.

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - `busy`=0, `load_ready`=0.
  - `load_start`=1 moves to LOAD and clears the write pointer, byte lane, assembly register and `words_loaded`.
- LOAD:
  - `busy`=1.
  - `load_ready`=1 unless the write pointer equals `DEPTH_WORDS`.
  - A byte is accepted when `load_valid && load_ready`. It goes into lane k at bits [8k+7:8k], and k increments mod 4.
  - The word is written to `mem[wptr]` on the edge where lane 3 is accepted, or where a byte with `load_last`=1 is accepted. Unfilled upper lanes are written as 0. Then `wptr++` and `words_loaded++`.
  - An accepted `load_last`, or `wptr` reaching `DEPTH_WORDS` after a write, moves to DONE.
  - `load_start` in LOAD is ignored.
- DONE: `load_done`=1 and `busy`=1 for one cycle, then IDLE unconditionally.
- Read path:
  - Word index = `rd_addr[31:2]`; `rd_addr[1:0]` is ignored.
  - `rd_data` = `NOP_WORD` if `busy`=1 or `rd_oor`=1; otherwise `mem[index]`.
  - `rd_oor` is independent of `busy`.
- Memory array:
  - Not cleared by reset.
  - Simulation initial contents are `NOP_WORD` in every word.
  - Words outside the loaded range keep their prior contents.

## Timing
- Reset values: state IDLE; `busy`, `load_ready`, `load_done` = 0; `words_loaded`, `wptr` and lane = 0; assembly register = 0.
- `busy`, `load_ready` and `load_done` are decoded from registered state. `busy` rises the cycle after `load_start` is sampled.
- Throughput: one byte per cycle while `load_valid` is held high; four cycles per word.
- Write-to-read latency: a word written on edge N is visible on `rd_data` from edge N onward, once `busy` drops.
- `busy` falls on the edge after DONE, so it is low 2 cycles after the final byte is accepted.
- Full memory: after word `DEPTH_WORDS-1` is written, `load_ready`=0 for the rest of the session, and extra bytes are not accepted.
- `load_last` on lane 3: a single write, no extra zero word.
- Reset mid-LOAD: state returns to IDLE. The partial word is discarded and already-written words are retained. `words_loaded` = 0.
- `rd_addr` changes are reflected combinationally, with no cycle of latency.

## Test plan
- Reset, then apply `rd_addr`=0 with nothing loaded. Required: `rd_data`=0x00000013, `busy`=0, `load_ready`=0, `words_loaded`=0.
- Pulse `load_start`, then stream bytes 93,00,50,00,13,01,01,00 (the last with `load_last`=1). Required:
  - `busy` is high the cycle after `load_start`.
  - `load_done` pulses once and `words_loaded`=2.
  - After `busy` falls: `rd_addr`=0 gives 0x00500093, and `rd_addr`=4 gives 0x00010113.
- While `busy`=1, apply `rd_addr`=0. Required: `rd_data`=`NOP_WORD`. Also confirm that `rd_addr`=1,2,3 return the same word as address 0 once idle.
- Stream 5 bytes AA,BB,CC,DD,EE with `load_last` on EE. Required: word0=0xDDCCBBAA, word1=0x000000EE, `words_loaded`=2.
- With `DEPTH_WORDS`=4, stream 20 bytes with `load_valid` held high. Required:
  - `load_ready` drops after byte 16.
  - `load_done` pulses and `words_loaded`=4.
  - `rd_addr`=16 gives `rd_oor`=1 and `NOP_WORD`.
- Assert reset after 6 bytes of a load. Required: FSM returns to IDLE, word0 holds its new value, word1 holds its prior value, and `busy`=0 the next cycle.
